rs_15_11_encoder: RTL and testbench

Systematic RS(15,11) encoder over GF(16) with 4-bit symbols. It is the transmit-side counterpart of the RS(15,11) decoder: it accepts 11 message symbols serially and emits the 15-symbol codeword, 11 message symbols passed through followed by 4 parity symbols. Its output format and field definition match what the decoder's syndrome and Euclid stages expect. Valid/ready handshakes on both sides; full throughput is 15 cycles per codeword.

---
 rtl/rs_15_11_encoder.sv | 135 +++++++++++++
 tb/tb_rs_15_11_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_15_11_encoder.sv
// Systematic RS(15,11) encoder over GF(16), primitive polynomial x^4+x+1.
// Eleven message symbols, highest-degree first, pass straight through to the
// output slot. They are followed by four parity symbols taken from a
// division LFSR with g(x) = x^4 + D x^3 + C x^2 + 8 x + 7.
// Optional feature macro: RS_ENC_ERR_INJECT_EN. When it is defined, an
// ERR_DATA port is added and its value is XORed into every symbol as the
// symbol is loaded into the output slot. The LFSR is never affected.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// valid never waits on ready. A presented symbol holds stable until it is
// taken. The single output slot can be drained and refilled in one cycle.
module rs_15_11_encoder (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [3:0] OUT_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       OUT_SOP,
    output logic       OUT_EOP,
`ifdef RS_ENC_ERR_INJECT_EN
    input  logic [3:0] ERR_DATA,
`endif
    output logic       DBG_STATE
);

    typedef enum logic {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] r3, r2, r1, r0;
    logic [3:0] mcnt, pcnt;
    logic       slot_free;
    logic       msg_load, par_load;
    logic [3:0] fb, fb_d, fb_c, fb_8, fb_7;
    logic [3:0] err;

    // GF(16) multiply, reduced by x^4+x+1. It is used only with constant
    // operands, so it collapses into a small XOR network.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] sh;
        p  = 4'h0;
        sh = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ sh;
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

`ifdef RS_ENC_ERR_INJECT_EN
    assign err = ERR_DATA;
`else
    assign err = 4'h0;
`endif

    assign fb        = IN_DATA ^ r3;
    assign fb_d      = gf_mul(fb, 4'hD);
    assign fb_c      = gf_mul(fb, 4'hC);
    assign fb_8      = gf_mul(fb, 4'h8);
    assign fb_7      = gf_mul(fb, 4'h7);
    assign DBG_STATE = (state_q == ST_PAR);

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_MSG;
        else          state_q <= state_d;
    end

    // Next-state logic, input ready, and slot load strobes.
    always_comb begin
        state_d   = state_q;
        slot_free = !OUT_VALID || OUT_READY;
        IN_READY  = 1'b0;
        msg_load  = 1'b0;
        par_load  = 1'b0;
        case (state_q)
            ST_MSG: begin
                IN_READY = slot_free;
                msg_load = IN_VALID && slot_free;
                if (msg_load && (mcnt == 4'd10)) state_d = ST_PAR;
            end
            ST_PAR: begin
                par_load = slot_free;
                if (par_load && (pcnt == 4'd3)) state_d = ST_MSG;
            end
            default: state_d = ST_MSG;
        endcase
    end

    // Output slot, LFSR and symbol counters. Four parity shifts leave the
    // LFSR empty, ready for the next codeword.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OUT_DATA  <= 4'h0;
            OUT_VALID <= 1'b0;
            OUT_SOP   <= 1'b0;
            OUT_EOP   <= 1'b0;
            r3        <= 4'h0;
            r2        <= 4'h0;
            r1        <= 4'h0;
            r0        <= 4'h0;
            mcnt      <= 4'd0;
            pcnt      <= 4'd0;
        end else if (msg_load) begin
            OUT_DATA  <= IN_DATA ^ err;
            OUT_VALID <= 1'b1;
            OUT_SOP   <= (mcnt == 4'd0);
            OUT_EOP   <= 1'b0;
            r3        <= r2 ^ fb_d;
            r2        <= r1 ^ fb_c;
            r1        <= r0 ^ fb_8;
            r0        <= fb_7;
            mcnt      <= (mcnt == 4'd10) ? 4'd0 : mcnt + 4'd1;
        end else if (par_load) begin
            OUT_DATA  <= r3 ^ err;
            OUT_VALID <= 1'b1;
            OUT_SOP   <= 1'b0;
            OUT_EOP   <= (pcnt == 4'd3);
            r3        <= r2;
            r2        <= r1;
            r1        <= r0;
            r0        <= 4'h0;
            pcnt      <= (pcnt == 4'd3) ? 4'd0 : pcnt + 4'd1;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_15_11_encoder.sv
// Bench for rs_15_11_encoder. A driver issues messages and pushes the
// expected codeword symbols, tagged with sop/eop, into exp_q. An
// independent monitor pops and compares on every output transfer. It also
// checks that each received codeword has zero syndromes at a^1..a^4.
// Expected codewords come from GF(16) log tables and polynomial long
// division by a generator built from its roots.
module tb_rs_15_11_encoder;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] IN_DATA = 4'h0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [3:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b1;
    logic       OUT_SOP;
    logic       OUT_EOP;
    logic [3:0] ERR_DATA = 4'h0;
    logic       DBG_STATE;

    typedef logic [3:0] msg_t [11];
    typedef logic [3:0] cw_t  [15];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         stall_en = 1'b0;
    bit         syn_en = 1'b1;
    logic [5:0] exp_q[$];
    int         out_cyc_q[$];
    logic [3:0] rx_q[$];
    int         alog[15];
    int         lg[16];
    logic [3:0] gen[5];

    rs_15_11_encoder dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .IN_DATA(IN_DATA),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_SOP(OUT_SOP),
        .OUT_EOP(OUT_EOP),
`ifdef RS_ENC_ERR_INJECT_EN
        .ERR_DATA(ERR_DATA),
`endif
        .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return 4'(alog[(lg[a] + lg[b]) % 15]);
    endfunction

    task automatic build_field();
        int v;
        logic [3:0] t[5];
        v = 1;
        for (int i = 0; i < 15; i++) begin
            alog[i] = v;
            lg[v]   = i;
            v = v << 1;
            if (v & 16) v = v ^ 'h13;
        end
        // g(x) = prod (x + a^i), i = 1..4, coefficients highest degree first
        gen[0] = 4'h1;
        for (int k = 1; k < 5; k++) gen[k] = 4'h0;
        for (int r = 1; r <= 4; r++) begin
            for (int j = 0; j < 5; j++) t[j] = gen[j];
            for (int j = 1; j <= r; j++) gen[j] = t[j] ^ gmul(t[j-1], 4'(alog[r]));
        end
    endtask

    function automatic cw_t encode(input msg_t m);
        logic [3:0] rem[15];
        logic [3:0] c;
        cw_t cw;
        for (int i = 0; i < 15; i++) rem[i] = (i < 11) ? m[i] : 4'h0;
        for (int i = 0; i < 11; i++) begin
            c = rem[i];
            for (int j = 0; j < 5; j++) rem[i+j] = rem[i+j] ^ gmul(c, gen[j]);
        end
        for (int i = 0; i < 15; i++) cw[i] = (i < 11) ? m[i] : rem[i];
        return cw;
    endfunction

    task automatic push_cw(input cw_t cw);
        for (int i = 0; i < 15; i++) exp_q.push_back({(i == 0), (i == 14), cw[i]});
    endtask

    // ---------------- output backpressure ----------------
    initial forever begin
        @(posedge CLK);
        #1;
        OUT_READY = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        logic [5:0] e;
        logic [3:0] s;
        @(negedge CLK);
        if (RESET_N && OUT_VALID && OUT_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got sop=%0b eop=%0b data=%h, required no output", OUT_SOP, OUT_EOP, OUT_DATA);
            end else begin
                e = exp_q.pop_front();
                if ({OUT_SOP, OUT_EOP, OUT_DATA} !== e) begin
                    errors++;
                    $display("FAIL out_symbol: got sop=%0b eop=%0b data=%h, required sop=%0b eop=%0b data=%h",
                             OUT_SOP, OUT_EOP, OUT_DATA, e[5], e[4], e[3:0]);
                end
            end
            out_cyc_q.push_back(cyc);
            rx_q.push_back(OUT_DATA);
            if (rx_q.size() == 15) begin
                if (syn_en) begin
                    for (int k = 1; k <= 4; k++) begin
                        s = 4'h0;
                        for (int i = 0; i < 15; i++)
                            s = s ^ gmul(rx_q[i], 4'(alog[(k * (14 - i)) % 15]));
                        checks++;
                        if (s !== 4'h0) begin
                            errors++;
                            $display("FAIL syndrome_s%0d: got %h, required 0", k, s);
                        end
                    end
                end
                rx_q.delete();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_sym(input logic [3:0] d, input logic [3:0] e);
        int n;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        ERR_DATA = e;
        n = 0;
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got IN_READY=0 for 200 cycles, required 1");
                break;
            end
        end
        @(posedge CLK);
        #1;
        ERR_DATA = 4'h0;
    endtask

    task automatic send_msg(input msg_t m, input bit gaps, input int err_idx);
        cw_t cw;
        cw = encode(m);
        if (err_idx >= 0) cw[err_idx] = cw[err_idx] ^ 4'h1;
        push_cw(cw);
        for (int i = 0; i < 11; i++) begin
            send_sym(m[i], (i == err_idx) ? 4'h1 : 4'h0);
            if (gaps && $urandom_range(0, 3) == 0) begin
                IN_VALID = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d symbols outstanding, required 0", name, exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({IN_READY, OUT_VALID, OUT_SOP, OUT_EOP, OUT_DATA} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL %s: got rdy=%0b vld=%0b sop=%0b eop=%0b data=%h, required rdy=1 vld=0 sop=0 eop=0 data=0",
                     name, IN_READY, OUT_VALID, OUT_SOP, OUT_EOP, OUT_DATA);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        msg_t m;
        cw_t  cw;
        build_field();

        // reset state
        repeat (3) @(posedge CLK);
        #2;
        check_idle("reset_hold");
        RESET_N = 1'b1;
        @(negedge CLK);
        check_idle("reset_release");
        @(posedge CLK);
        #1;

        // all-zero messages back-to-back, IN_VALID held through parity
        for (int i = 0; i < 11; i++) m[i] = 4'h0;
        out_cyc_q.delete();
        push_cw(encode(m));
        push_cw(encode(m));
        for (int i = 0; i < 22; i++) send_sym(4'h0, 4'h0);
        IN_VALID = 1'b0;
        wait_drain("zero");
        checks++;
        if (out_cyc_q.size() != 30 || (out_cyc_q[29] - out_cyc_q[0]) != 29) begin
            errors++;
            $display("FAIL stream_period: got %0d symbols over %0d cycles, required 30 over 29",
                     out_cyc_q.size(), (out_cyc_q.size() > 0) ? out_cyc_q[$] - out_cyc_q[0] : 0);
        end

        // single 1 in the last message slot gives parity D, C, 8, 7
        for (int i = 0; i < 15; i++) cw[i] = 4'h0;
        cw[10] = 4'h1; cw[11] = 4'hD; cw[12] = 4'hC; cw[13] = 4'h8; cw[14] = 4'h7;
        push_cw(cw);
        for (int i = 0; i < 11; i++) send_sym((i == 10) ? 4'h1 : 4'h0, 4'h0);
        IN_VALID = 1'b0;
        wait_drain("unit");

        // reset in mid-codeword
        stall_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m[i] = 4'($urandom_range(0, 15));
            exp_q.push_back({(i == 0), 1'b0, m[i]});
            send_sym(m[i], 4'h0);
        end
        IN_VALID = 1'b0;
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check_idle("reset_async");
        exp_q.delete();
        rx_q.delete();
        #12;
        RESET_N = 1'b1;
        @(negedge CLK);
        check_idle("reset_after_mid");
        @(posedge CLK);
        #1;
        for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(0, 15));
        send_msg(m, 1'b0, -1);
        wait_drain("post_reset");

        // random messages, random input gaps and output stalls
        stall_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(0, 15));
            send_msg(m, (n % 2) == 1, -1);
        end
        wait_drain("random");
        stall_en = 1'b0;

`ifdef RS_ENC_ERR_INJECT_EN
        // error on symbol 3 only, followed by a clean codeword
        syn_en = 1'b0;
        for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(0, 15));
        send_msg(m, 1'b0, 3);
        wait_drain("inject");
        syn_en = 1'b1;
        for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(0, 15));
        send_msg(m, 1'b0, -1);
        wait_drain("after_inject");
`endif

        repeat (5) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
